// File: rtl/vga_bus_initiator_if.sv
// Command/readback and 6502-style register bus signals of the vga bus initiator.
// The master modport is the initiator's view of these signals; slave is the peripheral/test side.
interface vga_bus_initiator_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_RW;
  logic [2:0] CMD_REG;
  logic [7:0] CMD_DATA;
  logic       RD_VALID;
  logic [7:0] RD_DATA;
  logic       BUSY;
  logic       PHI2;
  logic       EN;
  logic       RW;
  logic [2:0] REG;
  logic [7:0] DATA_OUT;
  logic       DATA_OE;
  logic [7:0] DATA_IN;

  modport master (
    input  CMD_VALID, CMD_RW, CMD_REG, CMD_DATA, DATA_IN,
    output CMD_READY, RD_VALID, RD_DATA, BUSY,
           PHI2, EN, RW, REG, DATA_OUT, DATA_OE
  );

  modport slave (
    output CMD_VALID, CMD_RW, CMD_REG, CMD_DATA, DATA_IN,
    input  CMD_READY, RD_VALID, RD_DATA, BUSY,
           PHI2, EN, RW, REG, DATA_OUT, DATA_OE
  );
endinterface

// File: rtl/vga_bus_initiator.sv
// Planck 6502 register-bus master: queues read/write commands and runs one bus
// cycle (low address phase, high data phase) per free-running PHI2 period.
module vga_bus_initiator #(
  parameter int unsigned PHI2_HALF  = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                CLK_12M,
  input  logic                RESETN,
  vga_bus_initiator_if.master bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (PHI2_HALF > 1) ? $clog2(PHI2_HALF) : 1;
  localparam logic [TW-1:0] LAST  = TW'(PHI2_HALF - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  typedef struct packed {
    logic       rw;
    logic [2:0] rg;
    logic [7:0] d;
  } cmd_t;

  logic [TW-1:0] r_cnt;
  logic          r_phi2;
  state_t        r_state, w_state_nx;
  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;

  logic       r_en, r_rw, r_doe, r_rdv;
  logic [2:0] r_reg;
  logic [7:0] r_dout, r_rdd;

  logic       w_en_nx, w_rw_nx, w_doe_nx, w_rdv_nx;
  logic [2:0] w_reg_nx;
  logic [7:0] w_dout_nx, w_rdd_nx;

  logic w_last, w_rise, w_fall;
  logic w_ready, w_push, w_pop, w_nonempty;
  cmd_t w_head, w_cmd_in;

  assign w_last     = (r_cnt == LAST);
  assign w_rise     = w_last && !r_phi2;
  assign w_fall     = w_last && r_phi2;
  assign w_ready    = (r_count < DEPTH);
  assign w_push     = bus.CMD_VALID && w_ready;
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rp];
  assign w_cmd_in   = {bus.CMD_RW, bus.CMD_REG, bus.CMD_DATA};

  always_comb begin
    w_state_nx = r_state;
    w_en_nx    = r_en;
    w_rw_nx    = r_rw;
    w_reg_nx   = r_reg;
    w_dout_nx  = r_dout;
    w_doe_nx   = r_doe;
    w_rdd_nx   = r_rdd;
    w_rdv_nx   = 1'b0;
    w_pop      = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_ADDR: begin
        if (w_rise) begin
          w_state_nx = ST_DATA;
          w_doe_nx   = !r_rw;
        end
      end
      ST_DATA: begin
        if (w_fall) begin
          w_doe_nx = 1'b0;
          if (r_rw) begin
            w_rdv_nx = 1'b1;
            w_rdd_nx = bus.DATA_IN;
          end
          w_state_nx = ST_IDLE;
          w_en_nx    = 1'b0;
          w_rw_nx    = 1'b1;
          w_reg_nx   = '0;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // Launch is shared by IDLE and the end of DATA, so queued commands run
    // back-to-back and override the return-to-idle values above.
    if (w_fall && w_nonempty && (r_state != ST_ADDR)) begin
      w_pop      = 1'b1;
      w_state_nx = ST_ADDR;
      w_en_nx    = 1'b1;
      w_rw_nx    = w_head.rw;
      w_reg_nx   = w_head.rg;
      w_doe_nx   = 1'b0;
      if (!w_head.rw) w_dout_nx = w_head.d;
    end
  end

  always_ff @(posedge CLK_12M) begin
    if (!RESETN) begin
      r_cnt   <= '0;
      r_phi2  <= 1'b0;
      r_state <= ST_IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_en    <= 1'b0;
      r_rw    <= 1'b1;
      r_reg   <= '0;
      r_dout  <= '0;
      r_doe   <= 1'b0;
      r_rdv   <= 1'b0;
      r_rdd   <= '0;
    end else begin
      if (w_last) begin
        r_cnt  <= '0;
        r_phi2 <= !r_phi2;
      end else begin
        r_cnt <= r_cnt + TW'(1);
      end
      r_state <= w_state_nx;
      r_en    <= w_en_nx;
      r_rw    <= w_rw_nx;
      r_reg   <= w_reg_nx;
      r_dout  <= w_dout_nx;
      r_doe   <= w_doe_nx;
      r_rdv   <= w_rdv_nx;
      r_rdd   <= w_rdd_nx;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK_12M) begin
    if (w_push) r_mem[r_wp] <= w_cmd_in;
  end

  assign bus.CMD_READY = w_ready;
  assign bus.BUSY      = w_nonempty || r_en;
  assign bus.PHI2      = r_phi2;
  assign bus.EN        = r_en;
  assign bus.RW        = r_rw;
  assign bus.REG       = r_reg;
  assign bus.DATA_OUT  = r_dout;
  assign bus.DATA_OE   = r_doe;
  assign bus.RD_VALID  = r_rdv;
  assign bus.RD_DATA   = r_rdd;

endmodule

// File: tb/tb_vga_bus_initiator.sv
// Scoreboarded bench for vga_bus_initiator: accepted commands are queued with
// their expected bus values and compared cycle by cycle as the bus plays them out.
module tb_vga_bus_initiator;

  typedef struct packed {
    logic       rw;
    logic [2:0] r;
    logic [7:0] d;
    logic [7:0] rd;
  } exp_t;

  logic CLK_12M;
  logic RESETN;
  vga_bus_initiator_if bus();

  vga_bus_initiator #(.PHI2_HALF(6), .FIFO_DEPTH(4)) dut (
    .CLK_12M(CLK_12M),
    .RESETN (RESETN),
    .bus    (bus)
  );

  logic [7:0] periph [8];
  exp_t       sb [$];
  exp_t       cur;
  int         pos = -1;
  int         n_checks = 0;
  int         n_errors = 0;
  int         rd_pulses = 0;
  int         en_run = 0;
  int         en_run_max = 0;
  bit         saw_full = 0;

  initial CLK_12M = 1'b0;
  always #5 CLK_12M = ~CLK_12M;

  // Peripheral returns its register contents only while selected in a read data phase.
  assign bus.DATA_IN = (bus.EN && bus.RW && bus.PHI2) ? periph[bus.REG] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge CLK_12M) begin
    if (!RESETN) begin
      pos    = -1;
      en_run = 0;
    end else begin
      if (bus.EN) en_run++;
      else en_run = 0;
      if (en_run > en_run_max) en_run_max = en_run;
      if (bus.RD_VALID) rd_pulses++;
      if (pos >= 0) pos++;
      if (pos == 12) begin
        if (cur.rw) begin
          check("rd_valid", bus.RD_VALID, 1);
          check("rd_data", bus.RD_DATA, cur.rd);
        end else begin
          check("wr_no_rdv", bus.RD_VALID, 0);
        end
        pos = -1;
      end else if (bus.RD_VALID) begin
        check("rdv_spurious", bus.RD_VALID, 0);
      end
      if (pos < 0) begin
        if (bus.EN) begin
          if (sb.size() == 0) check("cycle_no_cmd", bus.EN, 0);
          else begin
            cur = sb.pop_front();
            pos = 0;
          end
        end else begin
          check("idle_bus", {bus.RW, bus.REG, bus.DATA_OE}, {1'b1, 3'd0, 1'b0});
        end
      end
      if (pos >= 0) begin
        check("bus_cycle", {bus.EN, bus.RW, bus.REG, bus.PHI2, bus.DATA_OE},
              {1'b1, cur.rw, cur.r, (pos >= 6), (!cur.rw && pos >= 6)});
        if (!cur.rw) check("data_out", bus.DATA_OUT, cur.d);
      end
    end
  end

  // Call at a negedge or just after a posedge; returns 1 time unit after the accepting edge.
  task automatic push_cmd(input logic rw, input logic [2:0] r, input logic [7:0] d);
    bit acc = 0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_RW    = rw;
    bus.CMD_REG   = r;
    bus.CMD_DATA  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = bus.CMD_READY;
      if (!acc) saw_full = 1;
      @(posedge CLK_12M);
    end
    if (acc) sb.push_back('{rw, r, d, periph[r]});
    check("cmd_accepted", acc, 1);
    #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && bus.BUSY !== 1'b0; i++) @(negedge CLK_12M);
    check("idle_reached", bus.BUSY, 0);
  endtask

  task automatic align_boundary();
    for (int i = 0; i < 30 && bus.PHI2 !== 1'b1; i++) @(negedge CLK_12M);
    for (int i = 0; i < 30 && bus.PHI2 !== 1'b0; i++) @(negedge CLK_12M);
    check("boundary_found", bus.PHI2, 0);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge CLK_12M);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rp0;
    bit found;
    for (int i = 0; i < 8; i++) periph[i] = 8'h00;
    RESETN        = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_RW    = 1'b0;
    bus.CMD_REG   = 3'd0;
    bus.CMD_DATA  = 8'h00;

    // 1: reset state and PHI2 waveform
    repeat (3) @(posedge CLK_12M);
    #1;
    check("rst_ctrl", {bus.PHI2, bus.EN, bus.RW, bus.REG, bus.DATA_OE, bus.RD_VALID, bus.CMD_READY, bus.BUSY},
          {1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    check("rst_data", {bus.DATA_OUT, bus.RD_DATA}, 16'h0000);
    RESETN = 1'b1;
    for (int i = 0; i < 30 && bus.PHI2 !== 1'b1; i++) @(negedge CLK_12M);
    n = 0;
    while (bus.PHI2 === 1'b1 && n < 30) begin n++; @(negedge CLK_12M); end
    check("phi2_high_len", n, 6);
    n = 0;
    while (bus.PHI2 === 1'b0 && n < 30) begin n++; @(negedge CLK_12M); end
    check("phi2_low_len", n, 6);

    // 2: single write
    en_run_max = 0;
    push_cmd(1'b0, 3'd3, 8'hA5);
    check("busy_after_push", bus.BUSY, 1);
    wait_idle();
    check("t2_en_len", en_run_max, 12);
    check("t2_en_off", bus.EN, 0);

    // 3: five back-to-back writes
    clocks(5);
    saw_full   = 0;
    en_run_max = 0;
    align_boundary();
    for (int i = 0; i < 5; i++) push_cmd(1'b0, 3'(i), 8'(8'h10 + i));
    check("t3_ready_low_full", saw_full, 1);
    wait_idle();
    check("t3_en_continuous", en_run_max, 60);

    // 4: single read
    clocks(3);
    periph[5]  = 8'h3C;
    rp0        = rd_pulses;
    en_run_max = 0;
    push_cmd(1'b1, 3'd5, 8'hEE);
    wait_idle();
    clocks(20);
    check("t4_rd_held", bus.RD_DATA, 8'h3C);
    check("t4_one_pulse", rd_pulses - rp0, 1);
    check("t4_en_len", en_run_max, 12);

    // 5: read then write to the same register
    periph[2] = 8'h77;
    en_run_max = 0;
    push_cmd(1'b1, 3'd2, 8'h00);
    push_cmd(1'b0, 3'd2, 8'h01);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge CLK_12M);
      found = bus.RD_VALID;
    end
    check("t5_rdv_seen", found, 1);
    check("t5_write_addr", {bus.EN, bus.RW, bus.REG, bus.PHI2}, {1'b1, 1'b0, 3'd2, 1'b0});
    check("t5_rd_data", bus.RD_DATA, 8'h77);
    wait_idle();
    check("t5_en_len", en_run_max, 24);

    // 6: reset in the data phase of a read with two commands pending
    periph[6] = 8'h5A;
    rp0 = rd_pulses;
    align_boundary();
    push_cmd(1'b1, 3'd6, 8'h00);
    push_cmd(1'b0, 3'd1, 8'h21);
    push_cmd(1'b0, 3'd4, 8'h42);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge CLK_12M);
      #1;
      found = bus.EN && bus.RW && bus.PHI2;
    end
    check("t6_in_read_data", found, 1);
    RESETN = 1'b0;
    @(posedge CLK_12M);
    #1;
    check("t6_after_rst", {bus.EN, bus.DATA_OE, bus.BUSY, bus.CMD_READY, bus.RD_VALID},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    sb.delete();
    RESETN = 1'b1;
    en_run_max = 0;
    clocks(40);
    check("t6_no_rdv", rd_pulses - rp0, 0);
    check("t6_no_cycle", en_run_max, 0);
    check("t6_idle_busy", bus.BUSY, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
